// File: rtl/comb_answer_bcd_if.sv
// Handshake bundle between the combination controller and the BCD display stage.
// The controller side uses master, the converter side uses slave.
interface comb_answer_bcd_if #(
    parameter int WIDTH  = 15,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      answer;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output answer,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  answer,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/comb_answer_bcd.sv
// Binary-to-packed-BCD converter for the answer count.
// Uses a double-dabble loop that processes one bit per clock.
module comb_answer_bcd #(
    parameter int WIDTH  = 15,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    comb_answer_bcd_if.slave  io
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [BW-1:0]     scr_q, scr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              done_q, done_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] cat;

    // Add-3 on every digit that would overflow past 9 after doubling.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        cat = {adj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    bin_d   = io.answer;
                    scr_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d = cat[BW+WIDTH-1:WIDTH];
                bin_d = cat[WIDTH-1:0];
                cnt_d = cnt_q - 1'b1;
                // Result lands with the final shift so bcd and done align.
                if (cnt_q == CW'(1)) begin
                    bcd_d   = cat[BW+WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign io.busy = (state_q != S_IDLE);
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
endmodule

// File: tb/tb_comb_answer_bcd.sv
// Randomized self-checking bench for comb_answer_bcd.
// Expected digits come from decimal arithmetic on the captured answer.
module tb_comb_answer_bcd;
    localparam int WIDTH  = 15;
    localparam int DIGITS = 5;
    localparam int LAT    = WIDTH + 1;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [4*DIGITS-1:0] exp_bcd;

    comb_answer_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    comb_answer_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.answer = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_bcd = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 20'h0) begin
                n_err++;
                $display("FAIL reset k=%0d busy=%b done=%b bcd=%h want 0/0/00000",
                         k, bus.busy, bus.done, bus.bcd);
            end
        end
    endtask

    // One full conversion; start dropped after capture and answer scrambled.
    task automatic test_convert(input int v, input string tag);
        logic [4*DIGITS-1:0] want;
        int dones;
        want = to_bcd(v);
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.answer = WIDTH'(v);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.answer = WIDTH'($urandom);
            end
            if (bus.done === 1'b1) dones++;
            n_cmp++;
            if (bus.busy !== (k <= LAT) || bus.done !== (k == LAT)) begin
                n_err++;
                $display("FAIL %s timing k=%0d busy=%b done=%b want busy=%b done=%b",
                         tag, k, bus.busy, bus.done, k <= LAT, k == LAT);
            end
            n_cmp++;
            if (bus.bcd !== ((k >= LAT) ? want : exp_bcd)) begin
                n_err++;
                $display("FAIL %s bcd k=%0d got %h want %h", tag, k, bus.bcd,
                         (k >= LAT) ? want : exp_bcd);
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL %s pulses got %0d want 1", tag, dones);
        end
        exp_bcd = want;
    endtask

    task automatic test_basic();
        test_convert(12345, "basic");
    endtask

    task automatic test_boundaries();
        test_convert(0, "zero");
        test_convert(9, "nine");
        test_convert(10, "ten");
        test_convert(32767, "max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            test_convert(int'($urandom_range(0, 32767)), "rand");
        end
    endtask

    task automatic test_ignore_busy();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.answer = 15'd720;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            bus.start = (k == 3);
            bus.answer = (k == 3) ? 15'd24 : 15'd0;
            if (bus.done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 1 || bus.bcd !== 20'h00720) begin
            n_err++;
            $display("FAIL ignore pulses=%0d bcd=%h want 1 and 00720", dones, bus.bcd);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ignore busy=%b want 0", bus.busy);
        end
        exp_bcd = 20'h00720;
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.answer = 15'd5040;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_bcd = '0;
        for (int k = 0; k < LAT + 2; k++) begin
            n_cmp++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 20'h0) begin
                n_err++;
                $display("FAIL abort k=%0d busy=%b done=%b bcd=%h want 0/0/00000",
                         k, bus.busy, bus.done, bus.bcd);
            end
            if (k < LAT + 1) @(negedge clk);
        end
        n_cmp++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL abort early pulses got %0d want 0", dones);
        end
        test_convert(120, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        logic exp_done;
        logic [4*DIGITS-1:0] want;
        @(negedge clk);
        bus.start = 1'b1;
        bus.answer = 15'd6;
        for (int k = 1; k <= 2 * LAT + 3; k++) begin
            @(negedge clk);
            if (k == 1) bus.answer = 15'(3628 % 32768);
            if (k == LAT + 2) bus.start = 1'b0;
            exp_busy = (k <= LAT) || (k >= LAT + 2 && k <= 2 * LAT + 1);
            exp_done = (k == LAT) || (k == 2 * LAT + 1);
            want = (k >= 2 * LAT + 1) ? to_bcd(3628) :
                   (k >= LAT) ? to_bcd(6) : exp_bcd;
            n_cmp++;
            if (bus.busy !== exp_busy || bus.done !== exp_done) begin
                n_err++;
                $display("FAIL b2b timing k=%0d busy=%b done=%b want busy=%b done=%b",
                         k, bus.busy, bus.done, exp_busy, exp_done);
            end
            n_cmp++;
            if (bus.bcd !== want) begin
                n_err++;
                $display("FAIL b2b bcd k=%0d got %h want %h", k, bus.bcd, want);
            end
        end
        exp_bcd = to_bcd(3628);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.answer = '0;
        exp_bcd = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_busy();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
